// File: rtl/psi_pulse_gen_if.sv
// psi_pulse_gen_if: control/status bundle for the PSI pulse-train generator.
//   master : drives start/stop and the length/count settings, observes status
//   slave  : the generator itself
// Signals:
//   start, stop              request strobes
//   highLen, lowLen          phase length codes (phase lasts code+1 cycles)
//   pulseCount               pulses per train, 0 = continuous
//   PSI                      generated pulse line
//   busy, done               train in progress / finite train completed strobe
//   pulsesSent               completed high phases in current or last train
interface psi_pulse_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] highLen;
  logic [WIDTH-1:0] lowLen;
  logic [WIDTH-1:0] pulseCount;
  logic             PSI;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] pulsesSent;

  modport master (
    output start, stop, highLen, lowLen, pulseCount,
    input  PSI, busy, done, pulsesSent
  );

  modport slave (
    input  start, stop, highLen, lowLen, pulseCount,
    output PSI, busy, done, pulsesSent
  );
endinterface

// File: rtl/psi_pulse_gen.sv
// psi_pulse_gen: programmable PSI pulse-train generator.
// Produces pulses high for highLen+1 cycles and low for lowLen+1 cycles,
// either pulseCount pulses (done strobe at the end) or continuously
// (pulseCount=0) until stop.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  psi_pulse_gen_if.slave (start/stop/settings in, PSI/busy/done/pulsesSent out)
// Build option:
//   PSI_GEN_RELOAD_EN  when defined, highLen/lowLen are re-sampled from the
//                      inputs at every counter load instead of being held
//                      from start for the whole train.
module psi_pulse_gen #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  psi_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic             psi_q, psi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] high_src, low_src;

`ifdef PSI_GEN_RELOAD_EN
  // Lengths track the live inputs at each phase load.
  assign high_src = bus.highLen;
  assign low_src  = bus.lowLen;
`else
  logic [WIDTH-1:0] hlen_q, hlen_d;
  logic [WIDTH-1:0] llen_q, llen_d;

  assign high_src = hlen_q;
  assign low_src  = llen_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;
`ifndef PSI_GEN_RELOAD_EN
    hlen_d  = hlen_q;
    llen_d  = llen_q;
`endif
    case (state_q)
      IDLE: begin
        // stop has priority over start in IDLE.
        if (bus.start && !bus.stop) begin
          pcnt_d  = bus.pulseCount;
`ifndef PSI_GEN_RELOAD_EN
          hlen_d  = bus.highLen;
          llen_d  = bus.lowLen;
`endif
          sent_d  = '0;
          cnt_d   = bus.highLen;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          sent_d  = sent_q + WIDTH'(1);
          cnt_d   = low_src;
          state_d = LOW;
        end else begin
          cnt_d   = cnt_q - WIDTH'(1);
        end
      end
      LOW: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if ((pcnt_q != '0) && (sent_q == pcnt_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = high_src;
            state_d = HIGH;
          end
        end else begin
          cnt_d   = cnt_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they change on the
    // same edge as the state they describe.
    psi_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sent_q  <= '0;
      pcnt_q  <= '0;
      psi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      pcnt_q  <= pcnt_d;
      psi_q   <= psi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifndef PSI_GEN_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hlen_q <= '0;
      llen_q <= '0;
    end else begin
      hlen_q <= hlen_d;
      llen_q <= llen_d;
    end
  end
`endif

  assign bus.PSI        = psi_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pulsesSent = sent_q;

endmodule

// File: tb/tb_psi_pulse_gen.sv
// tb_psi_pulse_gen: directed bench for psi_pulse_gen.
// Per-cycle vector table for finite trains plus hand sequences for reset,
// stop, continuous wrap and length reload.
module tb_psi_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;

  psi_pulse_gen_if #(.WIDTH(8)) bus ();

  psi_pulse_gen #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] hl;
    logic [7:0] ll;
    logic [7:0] pc;
    logic       psi;
    logic       busy;
    logic       done;
    logic [7:0] sent;
  } vec_t;

  vec_t vt [25];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic [7:0] h,
                       input logic [7:0] l, input logic [7:0] c);
    bus.start      = s;
    bus.stop       = p;
    bus.highLen    = h;
    bus.lowLen     = l;
    bus.pulseCount = c;
  endtask

  initial begin
    int  rx_dur;
    int  rx_cap;
    logic prev_psi;
    logic [7:0] m_sent;
    logic m_psi;
    bit  saw_wrap;
    int  hi_len;
    int  exp_hi;
    int  guard;

    // start, stop, hl, ll, pc, psi, busy, done, sent
    vt[0]  = '{1'b1, 1'b0, 8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[1]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[2]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[3]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[4]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd1};
    vt[5]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd1};
    vt[6]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd1};
    vt[7]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd1};
    vt[8]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd1};
    vt[9]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd1};
    vt[10] = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd2};
    vt[11] = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd2};
    vt[12] = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd2, 1'b0, 1'b0, 1'b1, 8'd2};
    // back-to-back start on the edge after done, minimum lengths
    vt[13] = '{1'b1, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[14] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0, 8'd1};
    vt[15] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0, 8'd1};
    vt[16] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0, 8'd2};
    vt[17] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0, 8'd2};
    vt[18] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0, 8'd3};
    vt[19] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0, 8'd3};
    vt[20] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0, 8'd4};
    vt[21] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b1, 8'd4};
    vt[22] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0, 8'd4};
    // start and stop together in IDLE: stop wins
    vt[23] = '{1'b1, 1'b1, 8'd2, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0, 8'd4};
    vt[24] = '{1'b0, 1'b0, 8'd2, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0, 8'd4};

    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // Reset state
    #12;
    chk("reset_psi", int'(bus.PSI), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_sent", int'(bus.pulsesSent), 0);
    rst = 1'b1;
    step();

    // Table-driven finite trains
    rx_dur = 0;
    rx_cap = -1;
    prev_psi = 1'b0;
    for (int i = 0; i < 25; i++) begin
      drive(vt[i].start, vt[i].stop, vt[i].hl, vt[i].ll, vt[i].pc);
      step();
      chk($sformatf("vec%0d_psi", i), int'(bus.PSI), int'(vt[i].psi));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vt[i].busy));
      chk($sformatf("vec%0d_done", i), int'(bus.done), int'(vt[i].done));
      chk($sformatf("vec%0d_sent", i), int'(bus.pulsesSent), int'(vt[i].sent));
      // receiver: clear on rising edge, count each further high cycle
      if (bus.PSI && !prev_psi) rx_dur = 0;
      else if (bus.PSI) rx_dur++;
      if (!bus.PSI && prev_psi) rx_cap = rx_dur;
      prev_psi = bus.PSI;
      if (i == 12) chk("rx_duration", rx_cap, 3);
    end

    // Stop in the 2nd high cycle of a continuous train
    drive(1'b1, 1'b0, 8'd5, 8'd5, 8'd0);
    step();
    drive(1'b0, 1'b0, 8'd5, 8'd5, 8'd0);
    step();
    chk("stop_pre_psi", int'(bus.PSI), 1);
    bus.stop = 1'b1;
    step();
    chk("stop_psi", int'(bus.PSI), 0);
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_done", int'(bus.done), 0);
    chk("stop_sent", int'(bus.pulsesSent), 0);
    bus.stop = 1'b0;
    step();
    chk("stop_after_done", int'(bus.done), 0);
    chk("stop_after_busy", int'(bus.busy), 0);

    // Reset asserted mid-HIGH after one pulse completed
    drive(1'b1, 1'b0, 8'd1, 8'd0, 8'd0);
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("prerst_sent", int'(bus.pulsesSent), 1);
    step();
    chk("prerst_psi", int'(bus.PSI), 1);
    rst = 1'b0;
    #2;
    chk("midrst_psi", int'(bus.PSI), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_sent", int'(bus.pulsesSent), 0);
    #2;
    rst = 1'b1;
    step();
    step();
    chk("postrst_busy", int'(bus.busy), 0);
    chk("postrst_psi", int'(bus.PSI), 0);

    // Continuous wrap with ignored start pulses while busy
    drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    step();
    bus.start = 1'b0;
    m_psi = 1'b1;
    m_sent = 8'd0;
    saw_wrap = 1'b0;
    chk("cont_first_psi", int'(bus.PSI), 1);
    for (int c = 0; c < 600; c++) begin
      bus.start = (c % 7 == 3);
      step();
      if (m_psi) begin
        m_sent = m_sent + 8'd1;
        if (m_sent == 8'd0) saw_wrap = 1'b1;
      end
      m_psi = ~m_psi;
      chk("cont_psi", int'(bus.PSI), int'(m_psi));
      chk("cont_sent", int'(bus.pulsesSent), int'(m_sent));
      chk("cont_done", int'(bus.done), 0);
      chk("cont_busy", int'(bus.busy), 1);
    end
    chk("cont_wrapped", int'(saw_wrap), 1);
    drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    step();
    chk("cont_stop_busy", int'(bus.busy), 0);
    chk("cont_stop_sent_hold", int'(bus.pulsesSent), int'(m_sent));
    bus.stop = 1'b0;
    step();

    // Length change mid-train
`ifdef PSI_GEN_RELOAD_EN
    exp_hi = 7;
`else
    exp_hi = 3;
`endif
    drive(1'b1, 1'b0, 8'd2, 8'd1, 8'd3);
    step();
    bus.start = 1'b0;
    bus.highLen = 8'd6;
    guard = 0;
    while (bus.PSI && guard < 50) begin step(); guard++; end
    while (!bus.PSI && guard < 50) begin step(); guard++; end
    hi_len = 0;
    while (bus.PSI && guard < 50) begin hi_len++; step(); guard++; end
    chk("reload_timeout", int'(guard < 50), 1);
    chk("reload_high_len", hi_len, exp_hi);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("reload_stop_busy", int'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
